grant_handler: RTL and testbench

Client-side end of the round-robin arbiter handshake. Per-client request pulses go into saturating pending counters, which drive the arbiter `req` vector. The block accepts the arbiter's one-hot `grant`, serves the granted client for a programmable number of cycles, then returns `ack`/`load` so the arbiter's priority pointer rotates. It sits between the client request sources and the arbiter core.

---
 rtl/grant_handler_pkg.sv | 16 +
 rtl/grant_handler_pending_counter.sv | 46 ++++
 rtl/grant_handler.sv | 117 +++++++++++
 tb/tb_grant_handler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_handler_pkg.sv
// grant_handler_pkg: shared state encoding and grant helpers for grant_handler
package grant_handler_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1)) == '0);
    endfunction

endpackage

// File: rtl/grant_handler_pending_counter.sv
// pending_counter: saturating per-client request counter with sticky overflow
module pending_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] count_d, count_q;
    logic             ovf_d, ovf_q;

    // A lone increment saturates at MAX and flags overflow; inc with dec nets to no change
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc && !dec) begin
            if (count_q == MAX) ovf_d = 1'b1;
            else count_d = count_q + 1'b1;
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count and sticky overflow registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign nonzero  = count_q != '0;
    assign overflow = ovf_q;

endmodule

// File: rtl/grant_handler.sv
// grant_handler: client-side arbiter handshake with pending counters and timed service
module grant_handler
    import grant_handler_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_pulse,
    input  logic [WIDTH-1:0] grant,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] req,
    output logic             ack,
    output logic             load,
    output logic             busy,
    output logic [WIDTH-1:0] active,
    output logic [WIDTH-1:0] done,
    output logic [WIDTH-1:0] overflow,
    output logic             grant_err
);

    state_e                      state_d, state_q;
    logic [LEN_W-1:0]            cnt_d, cnt_q;
    logic [WIDTH-1:0]            active_d, active_q;
    logic [WIDTH-1:0]            done_d, done_q;
    logic                        ack_d, ack_q;
    logic                        busy_d, busy_q;
    logic                        err_d, err_q;
    logic                        accept;
    logic [WIDTH-1:0]            dec;
    logic [WIDTH-1:0]            nonzero;
    logic [WIDTH-1:0][CNT_W-1:0] pend;
    logic                        unused_pend;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pend
            pending_counter #(.CNT_W(CNT_W)) u_pend (
                .clk     (clk),
                .rst     (rst),
                .inc     (req_pulse[i]),
                .dec     (dec[i]),
                .count   (pend[i]),
                .nonzero (nonzero[i]),
                .overflow(overflow[i])
            );
        end
    endgenerate

    assign unused_pend = ^pend;
    assign req         = nonzero;
    assign accept      = (state_q == IDLE) && is_onehot(MAX_W'(grant)) && ((grant & nonzero) != '0);
    assign dec         = accept ? grant : '0;

    // Next state, service countdown and registered-output values decoded from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SERVE;
                    active_d = grant;
                    cnt_d    = (len == '0) ? LEN_W'(1) : len;
                end
            end
            SERVE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) state_d = ACK;
            end
            ACK: begin
                state_d  = IDLE;
                active_d = '0;
            end
            default: begin
                state_d  = IDLE;
                active_d = '0;
            end
        endcase
        err_d  = (state_q == IDLE) && (grant != '0) && !accept;
        ack_d  = state_d == ACK;
        busy_d = state_d != IDLE;
        done_d = (state_d == ACK) ? active_q : '0;
    end

    // FSM and output registers; reset aborts any service without an ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            done_q   <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign ack       = ack_q;
    assign load      = ack_q;
    assign busy      = busy_q;
    assign active    = active_q;
    assign done      = done_q;
    assign grant_err = err_q;

endmodule

// File: tb/tb_grant_handler.sv
// tb_grant_handler: scenario tasks plus randomized run against a timeline-based reference model
module tb_grant_handler;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int LEN_W = 4;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] req_pulse = '0;
    logic [WIDTH-1:0] grant = '0;
    logic [LEN_W-1:0] len = '0;
    logic [WIDTH-1:0] req, active, done, overflow;
    logic             ack, load, busy, grant_err;

    int n_pass = 0;
    int n_total = 0;

    int               m_pend [WIDTH];
    logic [WIDTH-1:0] m_ovf;
    logic [WIDTH-1:0] m_gnt;
    logic             m_err;
    int               m_a;
    int               m_l;
    int               edge_n = 0;

    always #5 clk = ~clk;

    grant_handler #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_pulse(req_pulse),
        .grant    (grant),
        .len      (len),
        .req      (req),
        .ack      (ack),
        .load     (load),
        .busy     (busy),
        .active   (active),
        .done     (done),
        .overflow (overflow),
        .grant_err(grant_err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Model: a service accepted at edge a with length L is busy after edges a..a+L, acks after a+L
    function automatic logic [WIDTH-1:0] exp_req();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = m_pend[i] > 0;
        return r;
    endfunction

    function automatic logic exp_busy();
        return edge_n >= m_a && edge_n <= m_a + m_l;
    endfunction

    function automatic logic exp_ack();
        return edge_n == m_a + m_l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) m_pend[i] = 0;
        m_ovf = '0;
        m_gnt = '0;
        m_err = 1'b0;
        m_a   = -100;
        m_l   = 0;
    endtask

    task automatic step(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g, input logic [LEN_W-1:0] l);
        logic acc;
        int   k;
        req_pulse = p;
        grant     = g;
        len       = l;
        @(posedge clk);
        edge_n++;
        acc   = 1'b0;
        m_err = 1'b0;
        if (edge_n >= m_a + m_l + 2 && g != '0) begin
            k = 0;
            for (int i = 0; i < WIDTH; i++) if (g[i]) k = i;
            if ($countones(g) == 1 && m_pend[k] > 0) begin
                acc   = 1'b1;
                m_a   = edge_n;
                m_l   = (l == '0) ? 1 : int'(l);
                m_gnt = g;
            end else begin
                m_err = 1'b1;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (p[i] && !(acc && g[i])) begin
                if (m_pend[i] == MAXP) m_ovf[i] = 1'b1;
                else m_pend[i]++;
            end else if (!p[i] && acc && g[i] && m_pend[i] > 0) begin
                m_pend[i]--;
            end
        end
        #1;
        req_pulse = '0;
        grant     = '0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40 && busy !== 1'b0; t++) step('0, '0, '0);
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            int k;
            k = -1;
            for (int i = WIDTH - 1; i >= 0; i--) if (m_pend[i] > 0) k = i;
            if (k < 0) break;
            step('0, WIDTH'(1) << k, LEN_W'($urandom_range(0, 2)));
            wait_idle();
        end
    endtask

    task automatic test_reset();
        logic [19:0] got;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        got = {req, ack, load, busy, active, done, overflow, grant_err};
        n_total++;
        if (got !== '0) $display("FAIL reset_init outputs got=%h exp=0", got);
        else n_pass++;
        rst = 1'b1;
        step(4'b0010, '0, '0);
        step('0, 4'b0010, 4'd5);
        step('0, '0, '0);
        step('0, '0, '0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_pre_busy got=%b exp=1", busy);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        got = {req, ack, load, busy, active, done, overflow, grant_err};
        n_total++;
        if (got !== '0) $display("FAIL reset_mid_serve outputs got=%h exp=0", got);
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            step('0, '0, '0);
            n_total++;
            if (ack !== 1'b0) $display("FAIL reset_no_ack cycle=%0d got=%b exp=0", k, ack);
            else n_pass++;
        end
        n_total++;
        if (req !== 4'b0000) $display("FAIL reset_req got=%b exp=0000", req);
        else n_pass++;
    endtask

    task automatic test_single();
        int nb;
        int ack_k;
        nb    = 0;
        ack_k = -1;
        step(4'b0010, '0, '0);
        n_total++;
        if (req !== 4'b0010) $display("FAIL single_req got=%b exp=0010", req);
        else n_pass++;
        step('0, 4'b0010, 4'd3);
        for (int k = 0; k < 5; k++) begin
            if (busy === 1'b1) nb++;
            if (ack === 1'b1 && ack_k < 0) ack_k = k;
            if (k < 3) begin
                n_total++;
                if (active !== 4'b0010) $display("FAIL single_active k=%0d got=%b exp=0010", k, active);
                else n_pass++;
            end
            if (k == 3) begin
                n_total++;
                if ({ack, load, done} !== 6'b11_0010) $display("FAIL single_ack got=%b exp=110010", {ack, load, done});
                else n_pass++;
            end
            step('0, '0, '0);
        end
        n_total++;
        if (nb !== 4) $display("FAIL single_busy_len got=%0d exp=4", nb);
        else n_pass++;
        n_total++;
        if (ack_k !== 3) $display("FAIL single_ack_offset got=%0d exp=3", ack_k);
        else n_pass++;
        n_total++;
        if (req !== 4'b0000) $display("FAIL single_req_after got=%b exp=0000", req);
        else n_pass++;
    endtask

    task automatic test_invalid();
        step(4'b0110, '0, '0);
        step('0, 4'b0110, 4'd2);
        n_total++;
        if ({grant_err, busy, req} !== 6'b10_0110) $display("FAIL invalid_multi got=%b exp=100110", {grant_err, busy, req});
        else n_pass++;
        step('0, 4'b1000, 4'd2);
        n_total++;
        if ({grant_err, busy, req} !== 6'b10_0110) $display("FAIL invalid_noreq got=%b exp=100110", {grant_err, busy, req});
        else n_pass++;
        step('0, '0, '0);
        n_total++;
        if (grant_err !== 1'b0) $display("FAIL invalid_pulse_width got=%b exp=0", grant_err);
        else n_pass++;
    endtask

    task automatic test_simul();
        step(4'b0100, 4'b0100, 4'd2);
        n_total++;
        if ({busy, active, req} !== 9'b1_0100_0110) $display("FAIL simul_accept got=%b exp=101000110", {busy, active, req});
        else n_pass++;
        wait_idle();
        n_total++;
        if (busy !== 1'b0) $display("FAIL simul_idle_timeout got=%b exp=0", busy);
        else n_pass++;
        n_total++;
        if (req[2] !== 1'b1) $display("FAIL simul_req2 got=%b exp=1", req[2]);
        else n_pass++;
        step('0, 4'b0100, 4'd1);
        wait_idle();
        n_total++;
        if (req[2] !== 1'b0) $display("FAIL simul_drained got=%b exp=0", req[2]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acks [$];
        int serve_n;
        serve_n = 0;
        step(4'b0011, '0, '0);
        step('0, 4'b0001, 4'd0);
        for (int k = 0; k < 6; k++) begin
            if (ack === 1'b1) acks.push_back(k);
            if (busy === 1'b1 && ack !== 1'b1) serve_n++;
            step('0, 4'b0010, 4'd0);
        end
        n_total++;
        if (acks.size() !== 2) $display("FAIL b2b_ack_count got=%0d exp=2", acks.size());
        else n_pass++;
        if (acks.size() == 2) begin
            n_total++;
            if (acks[1] - acks[0] !== 3) $display("FAIL b2b_ack_spacing got=%0d exp=3", acks[1] - acks[0]);
            else n_pass++;
        end
        n_total++;
        if (serve_n !== 2) $display("FAIL b2b_serve_cycles got=%0d exp=2", serve_n);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 9; k++) step(4'b0001, '0, '0);
        n_total++;
        if ({overflow, req} !== 8'b0001_0001) $display("FAIL sat_flags got=%b exp=00010001", {overflow, req});
        else n_pass++;
        for (int s = 0; s < 7; s++) begin
            n_total++;
            if (req[0] !== 1'b1) $display("FAIL sat_req_before service=%0d got=%b exp=1", s, req[0]);
            else n_pass++;
            step('0, 4'b0001, LEN_W'($urandom_range(0, 2)));
            wait_idle();
        end
        n_total++;
        if ({overflow, req} !== 8'b0001_0000) $display("FAIL sat_after got=%b exp=00010000", {overflow, req});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [19:0]      got;
        logic [19:0]      exp;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        int               mode;
        int               k;
        for (int c = 0; c < 400; c++) begin
            p    = WIDTH'($urandom_range(0, 15) & $urandom_range(0, 15));
            mode = $urandom_range(0, 9);
            g    = '0;
            if (mode < 5) begin
                k = $urandom_range(0, WIDTH - 1);
                if (m_pend[k] > 0) g = WIDTH'(1) << k;
            end else if (mode < 7) begin
                g = WIDTH'($urandom_range(0, 15));
            end
            step(p, g, LEN_W'($urandom_range(0, 3)));
            exp = {exp_req(), exp_ack(), exp_ack(), exp_busy(), exp_busy() ? m_gnt : 4'b0,
                   exp_ack() ? m_gnt : 4'b0, m_ovf, m_err};
            got = {req, ack, load, busy, active, done, overflow, grant_err};
            n_total++;
            if (got !== exp) $display("FAIL random cycle=%0d got=%h exp=%h", c, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_invalid();
        test_simul();
        drain();
        test_back_to_back();
        drain();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
